morse_rx: RTL and testbench
===========================

# morse_rx

Morse-code receiver that sits directly downstream of `ascii2morse`. It samples the serial on/off keyed line, measures mark and space durations in dot units of `PRESCALER` clock cycles, and assembles dots and dashes into characters. Decoded ASCII characters, including word-separating spaces, are queued in an internal FIFO. Output is the read-side mirror of the transmitter's `write_en`/`full` input: `read_en`/`empty`.

## Interface
- `PRESCALER`, 100: clock cycles per Morse dot unit; must match the transmitter; ≥ 4.
- `DEPTH`, 16: output FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all logic on rising edge.
- `srst`  in  1  reset, synchronous, active-high.
- `morse_in`  in  1  keyed line (1 = tone on); asynchronous to `clk`.
- `read_en`  in  1  pop the FIFO head; ignored while `empty`.
- `ascii_out`  out  8  FIFO head, first-word fall-through; 8'h00 when empty.
- `empty`  out  1  FIFO holds no characters.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full; cleared only by `srst`.

## Operation
- **Input path**
  - `morse_in` passes through a 2-flop synchronizer, then the optional glitch filter, giving the level `lvl`.
  - `run_cnt` counts cycles since the last `lvl` change.
  - `run_cnt` saturates at 7·PRESCALER and is width-sized for that value.
- **States:** IDLE, MARK, GAP.
- **IDLE**
  - No symbol is pending.
  - `lvl`=1 → MARK with `run_cnt` = 1.
  - Low level stays in IDLE, so leading silence is ignored.
- **MARK**
  - On the falling edge of `lvl`, the run is classified.
  - Run < 2·PRESCALER → dot (0); otherwise → dash (1). A saturated run counts as a dash.
  - The element is appended to the symbol shift register (6 bits), and the element count (0..7, saturating at 7) increments. Then → GAP.
- **GAP**
  - `lvl`=1 before 2·PRESCALER → MARK; this is an intra-character gap.
  - When `run_cnt` reaches exactly 2·PRESCALER, the character is emitted:
    - The symbol is looked up in the package table.
    - Count > 6 or an unmapped code emits '?' (8'h3F).
    - The symbol register is cleared, and the `letter_seen` flag is set.
  - When `run_cnt` reaches exactly 5·PRESCALER and `letter_seen`=1:
    - Emit ' ' (8'h20) and clear `letter_seen`.
    - → IDLE.
  - When 5·PRESCALER is reached with `letter_seen`=0, → IDLE silently.
- **Decode table:** A–Z map to uppercase, 0–9 to digits.
- **FIFO push rule**
  - A push is accepted if the FIFO is not full, or if `read_en` is high with `!empty` in the same cycle.
  - Otherwise the character is dropped and `overflow` is set.
- Pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.

## Timing
- **Reset values:** `empty`=1, `ascii_out`=8'h00, `overflow`=0, state IDLE, counters and symbol register 0, synchronizer flops 0.
- **Pipeline:** `lvl` lags `morse_in` by 2 cycles, plus 3 cycles when the glitch filter is enabled.
- **Push latency:** the push occurs in the cycle `run_cnt` hits the threshold. The character appears on `ascii_out`/`empty` on the next rising edge.
- **Pop:** `read_en` with `!empty` advances the head. The new head, or `empty`=1, is visible the following cycle.
- **Simultaneous push and pop on an empty FIFO:** the pop is ignored, the push lands, and `empty` falls next cycle.
- **`srst` mid-character:** discards the partial symbol and all FIFO contents. The first mark after reset starts a fresh character.

## Configuration
- `MORSE_RX_GLITCH_FILTER_EN`
  - **Defined:** `lvl` changes only after the synchronized input has differed from `lvl` for 4 consecutive cycles. Pulses of ≤ 3 cycles are invisible to the decoder.
  - **Undefined:** `lvl` equals the synchronized input, and every pulse of ≥ 1 cycle is decoded as an element.

## Structure
- **Package `morse_pkg`:**
  - Element-count and pattern typedefs.
  - Threshold multipliers (2 for dot/dash and letter gap, 5 for word gap, 7 for saturation).
  - ASCII constants for '?' and ' '.
  - `morse_lookup` function mapping count+pattern to ASCII, shared with `ascii2morse`'s encode table.
- **Sub-module `morse_rx_fifo`:** parameterized by DEPTH, with push, pop, head, empty, full and drop ports.

## Test plan
All scenarios use PRESCALER=100 and DEPTH=16 unless noted.
- **Reset:** hold `srst` for 5 cycles → `empty`=1, `ascii_out`=8'h00, `overflow`=0; idle-low input for 2000 cycles → nothing pushed.
- **Single letter:** 100 cycles high, then low → exactly one entry 8'h45 ('E'), visible 2+200+1 cycles after the falling edge; `read_en` for one cycle → `empty`=1.
- **Word and space:** drive `ascii2morse` output for "SOS", then 800 cycles low → FIFO reads 'S','O','S',' ' in order, with no leading space; a further 2000 cycles low produce no second space.
- **Invalid symbol:** 7 dots with 1-unit gaps, then a 3-unit gap → single '?' (8'h3F).
- **Overflow:** DEPTH=4, five 'E's without reads → 4 entries 'E', `overflow`=1 and remaining high after reads; `read_en` while empty → no state change.
- **Glitch filter and reset:** a 3-cycle high pulse during IDLE → nothing pushed with `MORSE_RX_GLITCH_FILTER_EN` defined, 'E' without it. `srst` mid-dash, then "T" → only 'T' (8'h54).

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: element/pattern types, timing multipliers, ASCII constants and the
// code table used by both the transmitter and the receiver.
package morse_pkg;

  typedef logic [2:0] elem_cnt_t;
  typedef logic [5:0] pattern_t;
  typedef enum logic [1:0] {StIdle, StMark, StGap} rx_state_t;

  localparam int unsigned MulLetter = 2;
  localparam int unsigned MulWord   = 5;
  localparam int unsigned MulSat    = 7;

  localparam logic [7:0] AsciiQuery = 8'h3F;
  localparam logic [7:0] AsciiSpace = 8'h20;

  // Pattern is right-aligned with the first element in the highest used bit; dot 0, dash 1.
  function automatic logic [7:0] morse_lookup(input elem_cnt_t cnt, input pattern_t pat);
    logic [7:0] ch;
    case ({cnt, pat})
      {3'd2, 6'b000001}: ch = 8'h41;  // A
      {3'd4, 6'b001000}: ch = 8'h42;
      {3'd4, 6'b001010}: ch = 8'h43;
      {3'd3, 6'b000100}: ch = 8'h44;
      {3'd1, 6'b000000}: ch = 8'h45;
      {3'd4, 6'b000010}: ch = 8'h46;
      {3'd3, 6'b000110}: ch = 8'h47;
      {3'd4, 6'b000000}: ch = 8'h48;
      {3'd2, 6'b000000}: ch = 8'h49;
      {3'd4, 6'b000111}: ch = 8'h4A;
      {3'd3, 6'b000101}: ch = 8'h4B;
      {3'd4, 6'b000100}: ch = 8'h4C;
      {3'd2, 6'b000011}: ch = 8'h4D;
      {3'd2, 6'b000010}: ch = 8'h4E;
      {3'd3, 6'b000111}: ch = 8'h4F;
      {3'd4, 6'b000110}: ch = 8'h50;
      {3'd4, 6'b001101}: ch = 8'h51;
      {3'd3, 6'b000010}: ch = 8'h52;
      {3'd3, 6'b000000}: ch = 8'h53;
      {3'd1, 6'b000001}: ch = 8'h54;
      {3'd3, 6'b000001}: ch = 8'h55;
      {3'd4, 6'b000001}: ch = 8'h56;
      {3'd3, 6'b000011}: ch = 8'h57;
      {3'd4, 6'b001001}: ch = 8'h58;
      {3'd4, 6'b001011}: ch = 8'h59;
      {3'd4, 6'b001100}: ch = 8'h5A;
      {3'd5, 6'b011111}: ch = 8'h30;  // 0
      {3'd5, 6'b001111}: ch = 8'h31;
      {3'd5, 6'b000111}: ch = 8'h32;
      {3'd5, 6'b000011}: ch = 8'h33;
      {3'd5, 6'b000001}: ch = 8'h34;
      {3'd5, 6'b000000}: ch = 8'h35;
      {3'd5, 6'b010000}: ch = 8'h36;
      {3'd5, 6'b011000}: ch = 8'h37;
      {3'd5, 6'b011100}: ch = 8'h38;
      {3'd5, 6'b011110}: ch = 8'h39;
      default:           ch = AsciiQuery;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/morse_rx_if.sv
// Character read-side bus of the Morse receiver: FWFT head, empty, pop and sticky overflow.
interface morse_rx_if;
  logic       read_en;
  logic [7:0] ascii_out;
  logic       empty;
  logic       overflow;

  modport master (output read_en, input ascii_out, empty, overflow);
  modport slave  (input read_en, output ascii_out, empty, overflow);
endinterface

// File: rtl/morse_rx_fifo.sv
// First-word fall-through character FIFO; extra pointer bit separates full from empty.
module morse_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_drop
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_pop, w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && !w_push;
  assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/morse_rx.sv
// Morse receiver: synchronizes the keyed line, times marks/spaces and queues decoded ASCII.
// Optional glitch filter enabled by defining MORSE_RX_GLITCH_FILTER_EN.
module morse_rx
  import morse_pkg::*;
#(
  parameter int unsigned PRESCALER = 100,
  parameter int unsigned DEPTH     = 16
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_morse,
  morse_rx_if.slave  bus
);
  localparam int unsigned CntW = $clog2(MulSat * PRESCALER + 1);
  localparam logic [CntW-1:0] LetterThr = CntW'(MulLetter * PRESCALER);
  localparam logic [CntW-1:0] WordThr   = CntW'(MulWord * PRESCALER);
  localparam logic [CntW-1:0] SatThr    = CntW'(MulSat * PRESCALER);

  logic            r_sync1, r_sync2, r_lvl_prev, w_lvl;
  logic [CntW-1:0] r_run_cnt;
  rx_state_t       r_state, w_state_nxt;
  pattern_t        r_sym, w_sym_nxt;
  elem_cnt_t       r_ecnt, w_ecnt_nxt;
  logic            r_seen, w_seen_nxt;
  logic            w_push, w_pop, w_empty, w_full, w_drop, r_overflow;
  logic [7:0]      w_push_data, w_head;

`ifdef MORSE_RX_GLITCH_FILTER_EN
  logic       r_lvl_flt, w_differ;
  logic [1:0] r_flt_cnt;

  // Level flips in the fourth consecutive cycle of disagreement.
  assign w_differ = (r_sync2 != r_lvl_flt);
  assign w_lvl    = (w_differ && r_flt_cnt == 2'd3) ? r_sync2 : r_lvl_flt;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_lvl_flt <= 1'b0;
      r_flt_cnt <= 2'd0;
    end else begin
      r_lvl_flt <= w_lvl;
      r_flt_cnt <= (w_differ && r_flt_cnt != 2'd3) ? r_flt_cnt + 2'd1 : 2'd0;
    end
  end
`else
  assign w_lvl = r_sync2;
`endif

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_lvl_prev <= 1'b0;
      r_run_cnt  <= '0;
      r_state    <= StIdle;
      r_sym      <= '0;
      r_ecnt     <= '0;
      r_seen     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_sync1    <= i_morse;
      r_sync2    <= r_sync1;
      r_lvl_prev <= w_lvl;
      if (w_lvl != r_lvl_prev)   r_run_cnt <= CntW'(1);
      else if (r_run_cnt != SatThr) r_run_cnt <= r_run_cnt + CntW'(1);
      r_state    <= w_state_nxt;
      r_sym      <= w_sym_nxt;
      r_ecnt     <= w_ecnt_nxt;
      r_seen     <= w_seen_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sym_nxt   = r_sym;
    w_ecnt_nxt  = r_ecnt;
    w_seen_nxt  = r_seen;
    w_push      = 1'b0;
    w_push_data = AsciiSpace;
    unique case (r_state)
      StIdle: if (w_lvl) w_state_nxt = StMark;
      StMark: begin
        // r_run_cnt holds the full mark length in the falling-edge cycle.
        if (!w_lvl) begin
          w_sym_nxt   = {r_sym[4:0], (r_run_cnt >= LetterThr)};
          if (r_ecnt != 3'd7) w_ecnt_nxt = r_ecnt + 3'd1;
          w_state_nxt = StGap;
        end
      end
      StGap: begin
        if (r_run_cnt == LetterThr) begin
          w_push      = 1'b1;
          w_push_data = (r_ecnt > 3'd6) ? AsciiQuery : morse_lookup(r_ecnt, r_sym);
          w_sym_nxt   = '0;
          w_ecnt_nxt  = '0;
          w_seen_nxt  = 1'b1;
        end else if (r_run_cnt == WordThr) begin
          w_push      = r_seen;
          w_seen_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
        if (w_lvl) w_state_nxt = StMark;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_pop = bus.read_en;

  morse_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_srst (i_srst),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_empty(w_empty),
    .o_full (w_full),
    .o_drop (w_drop)
  );

  assert property (@(posedge i_clk) disable iff (i_srst) w_drop |-> w_full);

  assign bus.ascii_out = w_head;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_morse_rx.sv
// Directed bench for morse_rx: two instances (DEPTH 16 and 4) share the keyed line and reset.
module tb_morse_rx;
  localparam int unsigned P = 100;
`ifdef MORSE_RX_GLITCH_FILTER_EN
  localparam int unsigned Lag = 5;
`else
  localparam int unsigned Lag = 2;
`endif

  logic clk = 1'b0;
  logic srst;
  logic morse;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  morse_rx_if u_if16 ();
  morse_rx_if u_if4 ();

  morse_rx #(.PRESCALER(P), .DEPTH(16)) u_dut16 (
    .i_clk  (clk),
    .i_srst (srst),
    .i_morse(morse),
    .bus    (u_if16.slave)
  );

  morse_rx #(.PRESCALER(P), .DEPTH(4)) u_dut4 (
    .i_clk  (clk),
    .i_srst (srst),
    .i_morse(morse),
    .bus    (u_if4.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(input int cycles);
    morse = 1'b1;
    tick(cycles);
    morse = 1'b0;
  endtask

  // Elements sent first-to-last from bit n-1 down; 1-unit gaps between elements.
  task automatic send_code(input int n, input logic [5:0] pat);
    for (int i = n - 1; i >= 0; i--) begin
      mark(pat[i] ? 3 * P : P);
      if (i != 0) tick(P);
    end
  endtask

  task automatic pop16(input string tag, input logic [7:0] exp);
    check_eq({tag, "_nonempty"}, u_if16.empty, 1'b0);
    check_eq(tag, u_if16.ascii_out, exp);
    u_if16.read_en = 1'b1;
    tick(1);
    u_if16.read_en = 1'b0;
  endtask

  task automatic pop4(input string tag, input logic [7:0] exp);
    check_eq(tag, u_if4.ascii_out, exp);
    u_if4.read_en = 1'b1;
    tick(1);
    u_if4.read_en = 1'b0;
  endtask

  task automatic do_reset();
    srst  = 1'b1;
    morse = 1'b0;
    tick(5);
    srst  = 1'b0;
  endtask

  initial begin
    srst = 1'b1;
    morse = 1'b0;
    u_if16.read_en = 1'b0;
    u_if4.read_en  = 1'b0;
    tick(5);
    check_eq("rst_empty", u_if16.empty, 1'b1);
    check_eq("rst_ascii", u_if16.ascii_out, 8'h00);
    check_eq("rst_ovf", u_if16.overflow, 1'b0);
    check_eq("rst_empty4", u_if4.empty, 1'b1);
    srst = 1'b0;
    tick(2000);
    check_eq("idle_empty", u_if16.empty, 1'b1);

    // Single 'E' with exact push latency, then the trailing word space.
    mark(P);
    tick(Lag + 200);
    check_eq("e_early", u_if16.empty, 1'b1);
    tick(1);
    pop16("e_head", 8'h45);
    check_eq("e_popped", u_if16.empty, 1'b1);
    tick(298);
    check_eq("sp_early", u_if16.empty, 1'b1);
    tick(1);
    pop16("e_space", 8'h20);

    // "SOS" followed by a long silence.
    send_code(3, 6'b000000);
    tick(3 * P);
    send_code(3, 6'b000111);
    tick(3 * P);
    send_code(3, 6'b000000);
    tick(800);
    pop16("sos_s1", 8'h53);
    pop16("sos_o", 8'h4F);
    pop16("sos_s2", 8'h53);
    pop16("sos_sp", 8'h20);
    check_eq("sos_empty", u_if16.empty, 1'b1);
    tick(2000);
    check_eq("sos_no_2nd_sp", u_if16.empty, 1'b1);
    check_eq("ovf4_sticky", u_if4.overflow, 1'b1);

    // Seven dots: too many elements for any character.
    for (int i = 0; i < 7; i++) begin
      mark(P);
      if (i != 6) tick(P);
    end
    tick(3 * P);
    pop16("inv_q", 8'h3F);
    check_eq("inv_single", u_if16.empty, 1'b1);
    tick(300);
    pop16("inv_sp", 8'h20);

    // Overflow on the DEPTH=4 instance.
    do_reset();
    check_eq("ovf4_rst", u_if4.overflow, 1'b0);
    repeat (5) begin
      mark(P);
      tick(3 * P);
    end
    check_eq("ovf4_set", u_if4.overflow, 1'b1);
    check_eq("ovf16_clr", u_if16.overflow, 1'b0);
    for (int i = 0; i < 4; i++) pop4("ovf4_e", 8'h45);
    check_eq("ovf4_empty", u_if4.empty, 1'b1);
    u_if4.read_en = 1'b1;
    tick(1);
    u_if4.read_en = 1'b0;
    check_eq("rd_empty_empty", u_if4.empty, 1'b1);
    check_eq("rd_empty_ascii", u_if4.ascii_out, 8'h00);
    check_eq("ovf4_held", u_if4.overflow, 1'b1);

    // Three-cycle pulse during idle.
    do_reset();
    tick(10);
    mark(3);
    tick(Lag + 201);
`ifdef MORSE_RX_GLITCH_FILTER_EN
    check_eq("glitch_ignored", u_if16.empty, 1'b1);
`else
    pop16("glitch_e", 8'h45);
`endif

    // Reset in the middle of a dash, then 'T'.
    mark(150);
    morse = 1'b1;
    tick(150);
    do_reset();
    check_eq("mid_rst_empty", u_if16.empty, 1'b1);
    tick(20);
    send_code(1, 6'b000001);
    tick(3 * P);
    pop16("t_head", 8'h54);
    check_eq("t_only", u_if16.empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
